// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle for onehot_scan_decoder.
//   master : control side, drives load/a/scan_en/dwell/hold, observes outputs
//   slave  : the decoder, observes the controls, drives b/idx/valid/err/wrap
interface onehot_scan_decoder_if #(
  parameter int N  = 80,
  parameter int AW = 7,
  parameter int DW = 16
);
  logic          load;
  logic [AW-1:0] a;
  logic          scan_en;
  logic [DW-1:0] dwell;
  logic          hold;
  logic [N-1:0]  b;
  logic [AW-1:0] idx;
  logic          valid;
  logic          err;
  logic          wrap;

  modport master (output load, a, scan_en, dwell, hold,
                  input  b, idx, valid, err, wrap);
  modport slave  (input  load, a, scan_en, dwell, hold,
                  output b, idx, valid, err, wrap);
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot channel decoder with direct load and auto-scan.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of onehot_scan_decoder_if
//          in : load, a, scan_en, dwell, hold
//          out: b (one-hot), idx, valid, err (sticky), wrap (1-cycle pulse)
// All outputs come straight from flops. Load always wins over scan/hold.
module onehot_scan_decoder #(
  parameter int N  = 80,
  parameter int AW = 7,
  parameter int DW = 16
) (
  input logic               clk,
  input logic               rst,
  onehot_scan_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  localparam logic [AW:0]   N_EXT = (AW+1)'(N);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);
  localparam logic [N-1:0]  B_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [N-1:0]  b_q, b_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          wrap_q, wrap_d;
  // cnt counts cycles spent at the current position; dlat is the dwell
  // captured when that position started, so mid-position dwell changes
  // only affect the next position.
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dlat_q, dlat_d;

  logic a_legal;
  assign a_legal = ({1'b0, bus.a} < N_EXT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      dlat_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      dlat_q  <= dlat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    b_d     = b_q;
    valid_d = valid_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    dlat_d  = dlat_q;
    if (bus.load) begin
      state_d = bus.scan_en ? SCAN : DIRECT;
      cnt_d   = '0;
      dlat_d  = bus.dwell;
      if (a_legal) begin
        idx_d   = bus.a;
        b_d     = B_ONE << bus.a;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        // idx is kept so a later scan entry resumes from it
        b_d     = '0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE, DIRECT: begin
          if (bus.scan_en) begin
            state_d = SCAN;
            b_d     = B_ONE << idx_q;
            valid_d = 1'b1;
            err_d   = 1'b0;
            cnt_d   = '0;
            dlat_d  = bus.dwell;
          end
        end
        SCAN: begin
          if (!bus.scan_en) begin
            state_d = DIRECT;
          end else if (!bus.hold && valid_q) begin
            // an illegal load while scanning leaves b empty; no advance then
            if (cnt_q == dlat_q) begin
              cnt_d  = '0;
              dlat_d = bus.dwell;
              if (idx_q == LAST) begin
                idx_d  = '0;
                b_d    = B_ONE;
                wrap_d = 1'b1;
              end else begin
                idx_d = idx_q + 1'b1;
                b_d   = b_q << 1;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.b     = b_q;
  assign bus.idx   = idx_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Parametrised, registered one-hot channel decoder; successor to the fixed 7-to-80 combinational decoder.
- Drives N one-hot select lines from a directly loaded index, or auto-scans all channels with a programmable dwell time.
- Sits between control logic and per-channel enable fabric: strobe arrays, mux selects, channel gating.
- Flags out-of-range indices instead of silently outputting zero.

Parameters:
- N, 80, number of one-hot outputs; legal range 2 ≤ N ≤ 2^AW.
- AW, 7, index width.
- DW, 16, dwell-count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  single-cycle request to load index a.
- a  in  AW  index to decode on load.
- scan_en  in  1  level; high = auto-scan mode.
- dwell  in  DW  extra cycles per scan position; 0 = advance every cycle.
- hold  in  1  level; freezes scanning (ignored outside SCAN).
- b  out  N  registered one-hot select, bit idx set.
- idx  out  AW  current index.
- valid  out  1  b holds a legal one-hot value.
- err  out  1  sticky out-of-range flag.
- wrap  out  1  one-cycle pulse when the scan wraps N-1 → 0.

Behaviour:
- Reset (async assert, sync release): b=0, idx=0, valid=0, err=0, wrap=0, dwell counter=0, state=IDLE.
- States: IDLE, DIRECT, SCAN. All outputs are registered.
- Load, a < N:
  - Next cycle: idx=a, b=1<<a, valid=1, err=0, dwell counter=0.
  - State becomes SCAN if scan_en is high, else DIRECT.
  - Latency is exactly 1 cycle.
- Load, a ≥ N:
  - Next cycle: b=0, valid=0, err=1, idx unchanged.
  - State becomes DIRECT, or SCAN if scan_en is high.
  - err stays high until a legal load, a scan entry, or reset.
- Priority: load beats scan advance and hold in the same cycle. The loaded index always appears, and the dwell counter restarts from 0.
- Scan entry (scan_en high, no load, state IDLE or DIRECT):
  - Next cycle: state=SCAN, b=1<<idx, valid=1, err=0, dwell counter=0.
  - Scanning starts from the current idx: 0 after reset; unchanged after an illegal load.
- In SCAN, each position is held for dwell+1 cycles:
  - dwell is sampled when a position starts; changes mid-position take effect at the next position.
  - On counter expiry: idx=idx+1 and b shifts left by one.
  - At idx=N-1: idx=0, b=1, and wrap=1 for exactly the cycle b=1 is first presented.
  - wrap is 0 at all other times.
- hold high in SCAN: idx, b and the dwell counter freeze. Release resumes with the remaining count.
- scan_en falls in SCAN: next cycle state=DIRECT; b/idx/valid keep their current values; no further advance.
- When N=2^AW, no a can be out of range and err never asserts.
- Invariant: b is either all zeros (valid=0) or has exactly one bit set equal to idx (valid=1).
- Reset mid-scan clears everything immediately, including a pending wrap pulse.

Test Plan:
1. Reset, then load=1 with a=79 for one cycle → next cycle b[79]=1 only, idx=79, valid=1, err=0; b holds in DIRECT.
2. Load a=80 → b=0, valid=0, err=1, idx keeps its previous value 79. Then load a=5 → b[5]=1, valid=1, err=0.
3. Load a=77, then scan_en=1, dwell=2 → b[77] for 3 cycles, then b[78], then b[79]. Next b[0] with wrap=1 for one cycle; then b[1] after 3 more cycles.
4. In SCAN with dwell=0, assert hold for 4 cycles at idx=10 → idx stays 10 throughout. After release idx=11 on the next cycle. Then drop scan_en → idx frozen.
5. scan_en=1 together with load a=40 in the same cycle → next cycle idx=40. Scanning resumes from 40 with a fresh dwell count, with no skipped or duplicated position.
6. Assert rst asynchronously mid-scan, between clock edges → b=0, idx=0, valid=0, err=0, wrap=0 immediately. With scan_en held high, after reset release the scan restarts from b[0].
